lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised synchronous LIFO stack; next-generation replacement for the fixed 4-bit, 5-entry stack. Adds configurable width and depth, same-cycle push+pop (replace-top and pass-through), occupancy count, programmable almost-full/almost-empty flags, a registered pop-valid strobe and sticky overflow/underflow error flags. Sits between a producer and a consumer that need last-in-first-out ordering, e.g. return-address or undo buffers.

## Interface
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of entries (>=2)
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
- CW, $clog2(DEPTH+1), width of count (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- push  in  1  write push_data onto the stack
- push_data  in  DATA_W  data to push
- pop  in  1  remove top entry to pop_data
- clear_err  in  1  clears sticky overflow/underflow
- pop_data  out  DATA_W  registered popped value; holds between pops
- pop_valid  out  1  one-cycle strobe: pop_data updated this cycle
- top  out  DATA_W  combinational peek of current top entry; 0 when empty
- count  out  CW  number of stored entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was refused

## Operation
- Storage: DEPTH x DATA_W register array; count doubles as write pointer; top entry is mem[count-1].
- push only, not full: mem[count] <= push_data, count+1.
- push only, full: write dropped, count unchanged, overflow <= 1.
- pop only, not empty: pop_data <= mem[count-1], pop_valid <= 1, count-1.
- pop only, empty: pop_data holds, pop_valid <= 0, underflow <= 1.
- push+pop, not empty (including full): pop_data <= mem[count-1], mem[count-1] <= push_data, pop_valid <= 1, count unchanged; no overflow even when full.
- push+pop, empty: pass-through: pop_data <= push_data, pop_valid <= 1, count stays 0, memory untouched, no error.
- Neither: no state change; pop_valid <= 0.
- clear_err clears both sticky flags; a new error in the same cycle wins (flag set).
- Reset: count 0, pop_data 0, pop_valid 0, overflow 0, underflow 0; memory contents not cleared (unobservable because top reads 0 when empty). Reset overrides push/pop in the same cycle; reset mid-operation discards all entries.
- count arithmetic is CW bits and never wraps: guarded at 0 and DEPTH.

## Timing
- pop_data/pop_valid: registered, valid the cycle after the edge sampling pop (1-cycle latency).
- count, full, empty, almost_*, top: reflect state after each edge; full/empty/almost_* and top are combinational decodes of count and memory, no extra latency.
- overflow/underflow: set at the edge sampling the offending request, visible next cycle.
- Back-to-back push or pop every cycle is supported at full throughput; no ready/stall handshake — callers gate on full/empty or observe error flags.

## Test plan
- Reset then push 0x11,0x22,0x33 on consecutive cycles, then pop x3 -> pop_data 0x33,0x22,0x11 with pop_valid high each cycle; count 3->0; empty=1 at end.
- Fill DEPTH=16 entries -> full=1, almost_full=1 from count 15; 17th push -> count stays 16, overflow=1 next cycle; top unchanged.
- Pop on empty -> pop_valid=0, pop_data holds previous value, underflow=1; clear_err -> underflow=0; clear_err with simultaneous empty pop -> underflow stays 1.
- With stack holding 0xA0,0xA1 (top), push 0xB0 + pop together -> pop_data=0xA1, top=0xB0, count stays 2; repeat when full -> no overflow, count 16.
- Empty stack, push 0x5C + pop together -> pop_data=0x5C, pop_valid=1, count 0, empty=1, no errors.
- Push 4 entries, assert reset with push high -> count 0, pop_data 0, pop_valid 0, flags 0, top 0; next pop -> underflow=1.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised synchronous LIFO with same-cycle push+pop, occupancy flags and sticky errors
module lifo_stack #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear_err,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_en;
  logic [AW-1:0]     wr_addr, top_idx;
  assign top_idx      = AW'(count_q - CW'(1));
  assign empty        = count_q == '0;
  assign full         = count_q == CW'(DEPTH);
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign top          = empty ? '0 : mem_q[top_idx];
  assign count        = count_q;
  assign pop_data     = pop_data_q;
  assign pop_valid    = pop_valid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  // next state: replace-top / pass-through on push+pop, guarded push or pop otherwise
  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = ovf_q & ~clear_err;
    udf_d       = udf_q & ~clear_err;
    wr_en       = 1'b0;
    wr_addr     = AW'(count_q);
    if (push && pop) begin
      pop_valid_d = 1'b1;
      pop_data_d  = empty ? push_data : top;
      wr_en       = ~empty;
      wr_addr     = top_idx;
    end else if (push) begin
      if (full) ovf_d = 1'b1;
      else begin
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end
    end else if (pop) begin
      if (empty) udf_d = 1'b1;
      else begin
        pop_data_d  = top;
        pop_valid_d = 1'b1;
        count_d     = count_q - CW'(1);
      end
    end
  end
  // control and output registers; reset discards all entries
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end
  // storage array is not reset; top masks stale contents while empty
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_addr] <= push_data;
  end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: queue-model checked directed and random stimulus for lifo_stack
module tb_lifo_stack;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic          clk = 1'b0;
  logic          reset, push, pop, clear_err;
  logic [DW-1:0] push_data, pop_data, top;
  logic          pop_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]    count;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_pd;
  logic          m_pv, m_ovf, m_udf;
  int            n_chk = 0, n_fail = 0;
  lifo_stack #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
    .clear_err(clear_err), .pop_data(pop_data), .pop_valid(pop_valid), .top(top),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    int n;
    n = q.size();
    chk("pop_data", pop_data, m_pd);
    chk("pop_valid", pop_valid, m_pv);
    chk("top", top, n > 0 ? q[n-1] : 8'h00);
    chk("count", count, n);
    chk("full", full, n == DEPTH);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= DEPTH - 1);
    chk("almost_empty", almost_empty, n <= 1);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
  endtask
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic o, input logic c, input logic r);
    int n;
    push = p; push_data = d; pop = o; clear_err = c; reset = r;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete();
      m_pd = '0; m_pv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_pv = 0;
      if (c) begin m_ovf = 0; m_udf = 0; end
      if (p && o) begin
        m_pv = 1;
        if (n == 0) m_pd = d;
        else begin m_pd = q[n-1]; q[n-1] = d; end
      end else if (p) begin
        if (n == DEPTH) m_ovf = 1;
        else q.push_back(d);
      end else if (o) begin
        if (n == 0) m_udf = 1;
        else begin m_pd = q.pop_back(); m_pv = 1; end
      end
    end
    #1;
    check_all();
  endtask
  initial begin
    reset = 1; push = 0; pop = 0; clear_err = 0; push_data = '0;
    m_pd = '0; m_pv = 0; m_ovf = 0; m_udf = 0;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'h11, 0, 0, 0); cyc(1, 8'h22, 0, 0, 0); cyc(1, 8'h33, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); chk("lifo_first", pop_data, 8'h33);
    cyc(0, 0, 1, 0, 0); chk("lifo_second", pop_data, 8'h22);
    cyc(0, 0, 1, 0, 0); chk("lifo_third", pop_data, 8'h11);
    chk("drained_empty", empty, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'($urandom), 0, 0, 0);
    chk("fill_full", full, 1);
    cyc(1, 8'hEE, 0, 0, 0); chk("overflow_set", overflow, 1); chk("overflow_count", count, 16);
    cyc(0, 0, 0, 1, 0); chk("overflow_clr", overflow, 0);
    cyc(1, 8'h77, 1, 0, 0); chk("full_replace_no_ovf", overflow, 0); chk("full_replace_top", top, 8'h77);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'hA0, 0, 0, 0); cyc(1, 8'hA1, 0, 0, 0);
    cyc(1, 8'hB0, 1, 0, 0); chk("replace_pop", pop_data, 8'hA1); chk("replace_top", top, 8'hB0); chk("replace_count", count, 2);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 8'h5C, 1, 0, 0); chk("pass_data", pop_data, 8'h5C); chk("pass_valid", pop_valid, 1); chk("pass_empty", empty, 1);
    cyc(0, 0, 1, 0, 0); chk("empty_pop_hold", pop_data, 8'h5C); chk("udf_set", underflow, 1);
    cyc(0, 0, 0, 1, 0); chk("udf_clr", underflow, 0);
    cyc(0, 0, 1, 1, 0); chk("udf_clr_wins", underflow, 1);
    for (int i = 0; i < 4; i++) cyc(1, DW'(i + 1), 0, 0, 0);
    cyc(1, 8'h99, 0, 0, 1); chk("rst_count", count, 0); chk("rst_top", top, 0);
    cyc(0, 0, 1, 0, 0); chk("rst_then_udf", underflow, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 45,
          $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
